// File: rtl/ysyx_23060278_wb_sched.sv
// Write-back scheduler and load scoreboard in front of the 32x32 GPR file.
// Arbitrates the single regfile write port between the execute path
// (absolute priority) and the in-order load return path. It also tracks
// the destinations of outstanding loads so that dependent instructions stall.
// A starvation counter throttles issue so that a refused load can drain.
module ysyx_23060278_wb_sched #(
  parameter int MAX_LOADS  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [4:0]                   issue_rs1,
  input  logic [4:0]                   issue_rs2,
  input  logic                         issue_use_rs1,
  input  logic                         issue_use_rs2,
  input  logic [4:0]                   issue_rd,
  input  logic                         issue_rd_wen,
  input  logic                         issue_is_load,
  input  logic [31:0]                  exec_data,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [31:0]                  lsu_data,
  output logic                         rf_w_en,
  output logic [4:0]                   rf_rd,
  output logic [31:0]                  rf_w_data,
  output logic [31:0]                  busy_mask,
  output logic [$clog2(MAX_LOADS):0]   load_cnt
);

  localparam int PW = $clog2(MAX_LOADS);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // One tag per outstanding load: whether its data must be written, and where.
  typedef struct packed {
    logic       wr;
    logic [4:0] rd;
  } tag_t;

  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          throttle_q, throttle_d;
  tag_t          tag_mem_q [MAX_LOADS];
  tag_t          tag_mem_d [MAX_LOADS];

  logic hazard, fire, exec_wr, push, lsu_hs;
  tag_t head, new_tag;

  // Hazard detection uses registered busy bits only: a bit clearing this
  // cycle still stalls, trading one bubble for a short timing path.
  always_comb begin
    hazard = throttle_q
           | (issue_use_rs1 & busy_q[issue_rs1])
           | (issue_use_rs2 & busy_q[issue_rs2])
           | (issue_rd_wen  & busy_q[issue_rd])
           | (issue_is_load & (cnt_q == CW'(MAX_LOADS)));
    issue_ready = !rst & !hazard;
    fire        = issue_valid & issue_ready;
    exec_wr     = fire & issue_rd_wen & !issue_is_load & (issue_rd != 5'd0);
    push        = fire & issue_is_load;
    new_tag.wr  = issue_rd_wen & (issue_rd != 5'd0);
    new_tag.rd  = issue_rd;
    head        = tag_mem_q[rd_ptr_q];
    lsu_ready   = (cnt_q != '0) & !exec_wr & !rst;
    lsu_hs      = lsu_valid & lsu_ready;
  end

  // Write-port mux: exec result first, else a flagged load return.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    rf_w_en   = 1'b0;
    rf_rd     = 5'd0;
    rf_w_data = 32'd0;
    if (exec_wr) begin
      rf_w_en   = 1'b1;
      rf_rd     = issue_rd;
      rf_w_data = exec_data;
    end else if (lsu_hs & head.wr) begin
      rf_w_en   = 1'b1;
      rf_rd     = head.rd;
      rf_w_data = lsu_data;
    end
  end

  // Next state for scoreboard, tag FIFO and starvation control.
  always_comb begin
    busy_d    = busy_q;
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + CW'(push) - CW'(lsu_hs);
    if (lsu_hs) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head.wr) busy_d[head.rd] = 1'b0;
    end
    if (push) begin
      tag_mem_d[wr_ptr_q] = new_tag;
      wr_ptr_d            = wr_ptr_q + PW'(1);
      if (new_tag.wr) busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (!lsu_valid || lsu_hs)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
    else
      starve_d = starve_q;
    throttle_d = (starve_d == SW'(STARVE_MAX));
  end

  // Control state with synchronous reset; a reset drops all outstanding tags.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      throttle_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      throttle_q <= throttle_d;
    end
  end

  // Tag storage.
  // NOTE: the tag array is deliberately not reset; an entry is only read
  // after it has been written, because cnt_q and the pointers are reset.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

  assign busy_mask = busy_q;
  assign load_cnt  = cnt_q;

endmodule
